uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, enabled clock cycles per serial bit, minimum 2.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  clock enable; the block advances only on cycles with en=1.
REQ-008 D  input  DATA_W  parallel data word, sampled only on frame acceptance.
REQ-009 baslat  input  1  start request, level-sampled.
REQ-010 y  output  1  serial line, idle high, registered.
REQ-011 mesgul  output  1  busy; high from the cycle after acceptance through the last stop-bit cycle, registered.
REQ-012 bitti  output  1  one-cycle done pulse at frame end, registered.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
REQ-014 In IDLE, y=1 and mesgul=0.
REQ-015 Frame acceptance SHALL occur in IDLE on a cycle with baslat=1 and en=1; D is latched into a shift register in that cycle.
REQ-016 baslat while mesgul=1 SHALL be ignored; the latched word SHALL NOT change mid-frame even if D changes.
REQ-017 The cycle after acceptance, the FSM enters START, with y=0 and mesgul=1.
REQ-018 Each bit (start, data, parity, stop) SHALL last exactly CLKS_PER_BIT cycles with en=1, timed by a baud counter that runs 0..CLKS_PER_BIT-1.
REQ-019 DATA SHALL transmit DATA_W bits LSB first, using a bit index counter 0..DATA_W-1.
REQ-020 PAR SHALL be present only when PARITY!=0.
REQ-021 With PARITY=1, the PAR bit is the XOR of the latched bits.
REQ-022 With PARITY=2, the PAR bit is the inverted XOR of the latched bits.
REQ-023 STOP SHALL drive y=1 for STOP_BITS*CLKS_PER_BIT enabled cycles.
REQ-024 On completion of STOP, the FSM returns to IDLE, mesgul falls and bitti=1 for exactly one cycle in that same cycle.
REQ-025 Acceptance SHALL be legal in the cycle bitti=1, giving back-to-back frames with exactly one idle-high cycle between the last stop cycle and the next start bit.
REQ-026 The total frame length SHALL be (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT enabled cycles.
REQ-027 en=0 SHALL freeze the FSM, baud counter, bit index and shift register, and hold y, mesgul and bitti at their values.
REQ-028 A bitti pulse SHALL NOT be stretched by en=0; bitti clears on the next clock edge regardless of en.
REQ-029 Counters SHALL be sized $clog2 of their range and SHALL never exceed their terminal value.
REQ-030 Illegal or unreachable FSM encodings SHALL recover to IDLE on the next edge.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE and zero all counters, giving y=1, mesgul=0 and bitti=0 in the next cycle.
REQ-032 reset SHALL take priority over en and baslat.
REQ-033 Reset mid-frame SHALL abort the frame with no bitti pulse.
REQ-034 After reset is released, the block SHALL accept a new frame on the first cycle with baslat=1 and en=1.

Verification
REQ-035 The bench SHALL cover frame A5h (DATA_W=8, CLKS_PER_BIT=4, PARITY=1, STOP_BITS=1, en=1): y = 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each held 4 cycles; mesgul high 44 cycles, then bitti pulse.
REQ-036 The bench SHALL cover odd parity, 2 stop bits, D=00h: parity bit 1, stop high 8 cycles, frame length 48 cycles.
REQ-037 The bench SHALL cover PARITY=0, DATA_W=5, D=1Bh: bits 1,1,0,1,1 after the start bit, no parity bit, 28-cycle frame.
REQ-038 The bench SHALL cover en toggling 1/0 every cycle during an A5h frame: identical bit sequence with each bit lasting 8 clk cycles, and y constant while en=0.
REQ-039 The bench SHALL cover baslat held high across two frames with D changed mid-frame: first frame carries the originally latched word, the second starts one cycle after bitti, and exactly one idle cycle separates them.
REQ-040 The bench SHALL cover reset asserted during the DATA bit 3: next cycle y=1, mesgul=0, no bitti pulse, and a new frame is accepted afterwards.

Source files
------------

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_param
//  Description : Parameterised UART transmitter with clock enable. It sends
//                a start bit, DATA_W data bits (LSB first), an optional
//                even/odd parity bit and one or two stop bits. Every bit
//                lasts CLKS_PER_BIT enabled clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
    parameter int DATA_W       = 8,   // data bits per frame, 5..9
    parameter int CLKS_PER_BIT = 16,  // enabled cycles per serial bit, >= 2
    parameter int PARITY       = 0,   // 0 none, 1 even, 2 odd
    parameter int STOP_BITS    = 1    // 1 or 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] D,
    input  logic              baslat,
    output logic              y,
    output logic              mesgul,
    output logic              bitti
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  C_DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  C_STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam bit                C_HAS_PAR   = (PARITY != 0);
    localparam bit                C_ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t              state_q,  state_d;
    logic [BAUD_W-1:0]   baud_q,   baud_d;
    logic [BIT_W-1:0]    bit_q,    bit_d;
    logic [DATA_W-1:0]   shreg_q,  shreg_d;
    logic                par_q,    par_d;
    logic                y_q,      y_d;
    logic                mesgul_q, mesgul_d;
    logic                bitti_q,  bitti_d;

    logic                baud_end;

    assign baud_end = (baud_q == C_BAUD_LAST);

    // Next-state logic: everything holds unless en=1; the done pulse defaults low.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        bitti_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && baslat) begin
                    state_d = S_START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shreg_d = D;
                    par_d   = C_ODD_PAR ? ~(^D) : (^D);
                end
            end

            S_START: begin
                if (en) begin
                    if (baud_end) begin
                        baud_d  = '0;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (en) begin
                    if (baud_end) begin
                        baud_d = '0;
                        if (bit_q == C_DATA_LAST) begin
                            bit_d   = '0;
                            state_d = C_HAS_PAR ? S_PAR : S_STOP;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = shreg_q >> 1;
                        end
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
            end

            S_PAR: begin
                if (en) begin
                    if (baud_end) begin
                        baud_d  = '0;
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (en) begin
                    if (baud_end) begin
                        baud_d = '0;
                        if (bit_q == C_STOP_LAST) begin
                            bit_d   = '0;
                            state_d = S_IDLE;
                            bitti_d = 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
            end

            // Unreachable encodings fall back to IDLE even while en=0.
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so that y and mesgul are registered.
    always_comb begin
        y_d = 1'b1;
        case (state_d)
            S_START: y_d = 1'b0;
            S_DATA:  y_d = shreg_d[0];
            S_PAR:   y_d = par_d;
            default: y_d = 1'b1;
        endcase
        mesgul_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            y_q      <= 1'b1;
            mesgul_q <= 1'b0;
            bitti_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            y_q      <= y_d;
            mesgul_q <= mesgul_d;
            bitti_q  <= bitti_d;
        end
    end

    assign y      = y_q;
    assign mesgul = mesgul_q;
    assign bitti  = bitti_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_param
//  Description : Self-checking bench for uart_tx_param. Three configurations
//                share one stimulus stream; a frame-level reference model
//                predicts every output cycle, and directed sequences check
//                the documented frames and corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

    localparam int NI = 3;
    localparam int P_DW  [NI] = '{8, 8, 5};
    localparam int P_CPB [NI] = '{4, 4, 4};
    localparam int P_PAR [NI] = '{1, 2, 0};
    localparam int P_SB  [NI] = '{1, 2, 1};

    logic          clk = 1'b0;
    logic          reset, en, baslat;
    logic [7:0]    D;
    logic [NI-1:0] y, m, b;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .en(en), .D(D), .baslat(baslat),
        .y(y[0]), .mesgul(m[0]), .bitti(b[0]));

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .reset(reset), .en(en), .D(D), .baslat(baslat),
        .y(y[1]), .mesgul(m[1]), .bitti(b[1]));

    uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u2 (
        .clk(clk), .reset(reset), .en(en), .D(D[4:0]), .baslat(baslat),
        .y(y[2]), .mesgul(m[2]), .bitti(b[2]));

    int unsigned cnt_checks = 0;
    int unsigned cnt_fail   = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        cnt_checks++;
        if (act !== exp) begin
            cnt_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        cnt_checks++;
        if (act != exp) begin
            cnt_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a frame is a list of line levels ----
    function automatic logic [15:0] build_frame(input logic [7:0] d, input int k);
        logic [15:0] f;
        logic        p;
        int          n;
        f    = '1;
        p    = 1'b0;
        f[0] = 1'b0;
        for (int i = 0; i < P_DW[k]; i++) begin
            f[1+i] = d[i];
            p      = p ^ d[i];
        end
        n = 1 + P_DW[k];
        if (P_PAR[k] == 1) f[n] = p;
        else if (P_PAR[k] == 2) f[n] = ~p;
        return f;
    endfunction

    function automatic int frame_cycles(input int k);
        return (1 + P_DW[k] + ((P_PAR[k] != 0) ? 1 : 0) + P_SB[k]) * P_CPB[k];
    endfunction

    bit          model_on = 1'b0;
    bit          mbusy  [NI];
    int          midx   [NI];
    logic [15:0] mframe [NI];
    logic        ey [NI];
    logic        em [NI];
    logic        eb [NI];

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                mbusy[k] = 1'b0;
                ey[k] = 1'b1; em[k] = 1'b0; eb[k] = 1'b0;
            end else if (en) begin
                eb[k] = 1'b0;
                if (mbusy[k]) begin
                    midx[k] = midx[k] + 1;
                    if (midx[k] == frame_cycles(k)) begin
                        mbusy[k] = 1'b0;
                        ey[k] = 1'b1; em[k] = 1'b0; eb[k] = 1'b1;
                    end else begin
                        ey[k] = mframe[k][midx[k] / P_CPB[k]];
                        em[k] = 1'b1;
                    end
                end else if (baslat) begin
                    mframe[k] = build_frame(D, k);
                    mbusy[k]  = 1'b1;
                    midx[k]   = 0;
                    ey[k] = 1'b0; em[k] = 1'b1;
                end
            end else begin
                eb[k] = 1'b0;
            end
        end
        if (reset) model_on = 1'b1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (model_on) begin
            for (int k = 0; k < NI; k++) begin
                chk1($sformatf("model_y[%0d]", k), y[k], ey[k]);
                chk1($sformatf("model_mesgul[%0d]", k), m[k], em[k]);
                chk1($sformatf("model_bitti[%0d]", k), b[k], eb[k]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic tr0[$];
    logic tr1[$];
    logic tr2[$];

    // Record each instance's line level for every cycle it is busy.
    task automatic capture(input bit tog, input int maxc);
        int c;
        c = 0;
        tr0.delete(); tr1.delete(); tr2.delete();
        while ((m != '0) && (c < maxc)) begin
            if (m[0]) tr0.push_back(y[0]);
            if (m[1]) tr1.push_back(y[1]);
            if (m[2]) tr2.push_back(y[2]);
            if (tog) en = ~en;
            step();
            c++;
        end
        chkn("capture_bound", (c < maxc) ? 1 : 0, 1);
        en = 1'b1;
    endtask

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       st;
        logic [7:0] d;
        logic       xy;
        logic       xm;
        logic       xb;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic s,
                                input logic [7:0] d, input logic xy,
                                input logic xm, input logic xb);
        vec_t v;
        v.rst = r; v.en = e; v.st = s; v.d = d;
        v.xy = xy; v.xm = xm; v.xb = xb;
        return v;
    endfunction

    vec_t tbl[$];

    // Frame level lists, element i at bit i.
    logic [10:0] seq_a5  = 11'b10101001010;
    logic [10:0] seq_3c  = 11'b10001111000;
    logic [10:0] seq_5a  = 11'b10010110100;
    logic [11:0] seq_odd = 12'b111000000000;
    logic [6:0]  seq_1b  = 7'b1110110;

    logic ya [100];
    logic ma [100];
    logic ba [100];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b1; baslat = 1'b0; D = 8'h00;
        step(); step();

        // Reset beats start, then A5h even parity frame on u0.
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0));
        for (int i = 1; i < 44; i++)
            tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h3C, seq_a5[i/4], 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            reset = tbl[i].rst; en = tbl[i].en; baslat = tbl[i].st; D = tbl[i].d;
            step();
            chk1($sformatf("tbl_y[%0d]", i), y[0], tbl[i].xy);
            chk1($sformatf("tbl_mesgul[%0d]", i), m[0], tbl[i].xm);
            chk1($sformatf("tbl_bitti[%0d]", i), b[0], tbl[i].xb);
        end

        // Odd parity, two stop bits, D=00h on u1.
        D = 8'h00; baslat = 1'b1; step(); baslat = 1'b0;
        capture(1'b0, 200);
        chkn("odd2_len", tr1.size(), 48);
        for (int i = 0; i < 48; i++)
            if (i < tr1.size()) chk1($sformatf("odd2_y[%0d]", i), tr1[i], seq_odd[i/4]);

        // No parity, five data bits, D=1Bh on u2.
        D = 8'h1B; baslat = 1'b1; step(); baslat = 1'b0;
        capture(1'b0, 200);
        chkn("w5_len", tr2.size(), 28);
        for (int i = 0; i < 28; i++)
            if (i < tr2.size()) chk1($sformatf("w5_y[%0d]", i), tr2[i], seq_1b[i/4]);

        // en toggling every cycle stretches each bit to 8 clocks.
        D = 8'hA5; baslat = 1'b1; step(); baslat = 1'b0;
        capture(1'b1, 400);
        chkn("entog_len", tr0.size(), 88);
        for (int i = 0; i < 88; i++)
            if (i < tr0.size()) chk1($sformatf("entog_y[%0d]", i), tr0[i], seq_a5[i/8]);

        // baslat held high: back-to-back frames, D changed mid-frame.
        D = 8'hA5; baslat = 1'b1; step(); D = 8'h3C;
        for (int c = 0; c < 100; c++) begin
            ya[c] = y[0]; ma[c] = m[0]; ba[c] = b[0];
            if (c == 45) begin
                baslat = 1'b0;
                D = 8'hFF;
            end
            step();
        end
        for (int c = 0; c < 44; c++) begin
            chk1($sformatf("b2b_f1_y[%0d]", c), ya[c], seq_a5[c/4]);
            chk1($sformatf("b2b_f1_m[%0d]", c), ma[c], 1'b1);
        end
        chk1("b2b_gap_y", ya[44], 1'b1);
        chk1("b2b_gap_m", ma[44], 1'b0);
        chk1("b2b_gap_bitti", ba[44], 1'b1);
        for (int c = 45; c < 89; c++) begin
            chk1($sformatf("b2b_f2_y[%0d]", c), ya[c], seq_3c[(c-45)/4]);
            chk1($sformatf("b2b_f2_m[%0d]", c), ma[c], 1'b1);
        end
        chk1("b2b_end_m", ma[89], 1'b0);
        chk1("b2b_end_bitti", ba[89], 1'b1);

        // Reset during data bit 3 aborts the frame without a done pulse.
        D = 8'hA5; baslat = 1'b1; step(); baslat = 1'b0;
        for (int c = 0; c < 17; c++) step();
        chk1("abort_pre_y", y[0], seq_a5[4]);
        chk1("abort_pre_m", m[0], 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        chk1("abort_y", y[0], 1'b1);
        chk1("abort_m", m[0], 1'b0);
        chk1("abort_bitti", b[0], 1'b0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk1($sformatf("abort_quiet_bitti[%0d]", c), b[0], 1'b0);
        end
        D = 8'h5A; baslat = 1'b1; step(); baslat = 1'b0;
        capture(1'b0, 200);
        chkn("abort_next_len", tr0.size(), 44);
        for (int i = 0; i < 44; i++)
            if (i < tr0.size()) chk1($sformatf("abort_next_y[%0d]", i), tr0[i], seq_5a[i/4]);

        // Random traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            en     = ($urandom_range(0, 3) != 0);
            baslat = ($urandom_range(0, 4) == 0);
            D      = 8'($urandom);
            reset  = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; en = 1'b1; baslat = 1'b0;
        for (int c = 0; c < 200; c++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", cnt_checks, cnt_fail);
        $finish;
    end

endmodule
`default_nettype wire
